// File: rtl/ddr_pkg.sv
// Shared FSM encoding, score width and default lane geometry for the DDR note sequencer.
// The defaults are the same window and geometry constants the vga renderer uses.
package ddr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SCORE_W = 10;

    localparam int DEF_N_SLOTS    = 4;
    localparam int DEF_Y_W        = 10;
    localparam int DEF_SPAWN_Y    = 480;
    localparam int DEF_STEP       = 4;
    localparam int DEF_HIT_LO     = 40;
    localparam int DEF_HIT_HI     = 72;
    localparam int DEF_MISS_Y     = 8;
    localparam int DEF_BEAT_TICKS = 16;
    localparam int DEF_PAT_LEN    = 64;
    localparam logic [63:0] DEF_PATTERN = 64'h1111_1111_1111_1111;

    // HUD counters stick at all-ones instead of wrapping.
    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] v, input logic [1:0] inc);
        logic [SCORE_W:0] sum;
        sum = {1'b0, v} + {{(SCORE_W-1){1'b0}}, inc};
        return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
    endfunction

endpackage

// File: rtl/ddr_note_fifo.sv
// Ring buffer of live arrows: push at tail, pop at head, and a strobe that scrolls every
// occupied slot up by STEP. Slot storage doubles as the renderer-facing valid/y registers.
module ddr_note_fifo
    import ddr_pkg::*;
#(
    parameter int N_SLOTS = DEF_N_SLOTS,
    parameter int Y_W     = DEF_Y_W,
    parameter int STEP    = DEF_STEP
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [Y_W-1:0]               push_y,
    input  logic                         pop,
    input  logic                         dec,
    output logic [Y_W-1:0]               head_y,
    output logic [$clog2(N_SLOTS+1)-1:0] count,
    output logic [N_SLOTS-1:0]           slot_valid,
    output logic [N_SLOTS*Y_W-1:0]       slot_y
);

    localparam int PTR_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
    localparam int CNT_W = $clog2(N_SLOTS + 1);
    localparam logic [Y_W-1:0]   STEP_Y = Y_W'(STEP);
    localparam logic [CNT_W-1:0] FULL   = CNT_W'(N_SLOTS);

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && (count != FULL);
    assign head_y  = slot_y[head*Y_W +: Y_W];

    // A freshly pushed arrow keeps SPAWN_Y for its first cycle; a popped slot is cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            slot_valid <= '0;
            slot_y     <= '0;
        end else begin
            for (int i = 0; i < N_SLOTS; i++) begin
                if (do_pop && (PTR_W'(i) == head)) begin
                    slot_valid[i]          <= 1'b0;
                    slot_y[i*Y_W +: Y_W]   <= '0;
                end else if (do_push && (PTR_W'(i) == tail)) begin
                    slot_valid[i]          <= 1'b1;
                    slot_y[i*Y_W +: Y_W]   <= push_y;
                end else if (dec && slot_valid[i]) begin
                    slot_y[i*Y_W +: Y_W]   <= slot_y[i*Y_W +: Y_W] - STEP_Y;
                end
            end
            if (do_pop) begin
                head <= head + PTR_W'(1);
            end
            if (do_push) begin
                tail <= tail + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ddr_note_sequencer.sv
// DDR lane scheduler: walks the beat pattern, spawns and scrolls arrows, judges presses.
// Define DDR_COMBO_EN to build the streak counters behind o_combo / o_max_combo.
module ddr_note_sequencer
    import ddr_pkg::*;
#(
    parameter int N_SLOTS    = DEF_N_SLOTS,
    parameter int Y_W        = DEF_Y_W,
    parameter int SPAWN_Y    = DEF_SPAWN_Y,
    parameter int STEP       = DEF_STEP,
    parameter int HIT_LO     = DEF_HIT_LO,
    parameter int HIT_HI     = DEF_HIT_HI,
    parameter int MISS_Y     = DEF_MISS_Y,
    parameter int BEAT_TICKS = DEF_BEAT_TICKS,
    parameter int PAT_LEN    = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(DEF_PATTERN)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   mov_tick,
    input  logic                   btn_up,
    output logic [N_SLOTS-1:0]     o_valid,
    output logic [N_SLOTS*Y_W-1:0] o_y,
    output logic [SCORE_W-1:0]     o_score,
    output logic [SCORE_W-1:0]     o_miss,
    output logic                   o_playing,
    output logic                   o_done,
    output logic                   o_overflow,
    output logic [SCORE_W-1:0]     o_combo,
    output logic [SCORE_W-1:0]     o_max_combo
);

    localparam int CNT_W  = $clog2(N_SLOTS + 1);
    localparam int BEAT_W = (BEAT_TICKS > 1) ? $clog2(BEAT_TICKS) : 1;
    localparam int STEP_W = $clog2(PAT_LEN + 1);
    localparam int IDX_W  = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
    localparam logic [Y_W-1:0]    STEP_Y    = Y_W'(STEP);
    localparam logic [Y_W-1:0]    HIT_LO_Y  = Y_W'(HIT_LO);
    localparam logic [Y_W-1:0]    HIT_HI_Y  = Y_W'(HIT_HI);
    localparam logic [Y_W-1:0]    MISS_Y_Y  = Y_W'(MISS_Y);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_TICKS - 1);
    localparam logic [STEP_W-1:0] STEP_END  = STEP_W'(PAT_LEN);
    localparam logic [CNT_W-1:0]  FULL      = CNT_W'(N_SLOTS);

    state_t            state;
    state_t            state_next;
    logic [BEAT_W-1:0] beat_cnt;
    logic [STEP_W-1:0] pat_step;
    logic              btn_q;
    logic              press_q;
    logic [Y_W-1:0]    head_y;
    logic [Y_W-1:0]    head_after;
    logic [CNT_W-1:0]  count;
    logic              playing;
    logic              song_start;
    logic              empty;
    logic              beat_wrap;
    logic              spawn_req;
    logic              push;
    logic              pop;
    logic              press_hit;
    logic              press_bad;
    logic              tick_miss;
    logic [1:0]        miss_inc;

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (start) state_next = PLAY;
            PLAY:       if (pat_step == STEP_END && count == '0) state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    assign playing    = (state == PLAY);
    assign song_start = start && !playing;
    assign empty      = (count == '0);
    assign head_after = head_y - STEP_Y;
    assign beat_wrap  = playing && mov_tick && (pat_step != STEP_END) && (beat_cnt == BEAT_LAST);
    assign spawn_req  = beat_wrap && PATTERN[pat_step[IDX_W-1:0]];
    assign push       = spawn_req && (count != FULL);

    // A hit wins the single retire slot, so the tick's miss check stands down that cycle.
    assign press_hit  = playing && press_q && !empty && (head_y >= HIT_LO_Y) && (head_y <= HIT_HI_Y);
    assign press_bad  = playing && press_q && !press_hit;
    assign tick_miss  = playing && mov_tick && !press_hit && !empty && (head_after < MISS_Y_Y);
    assign pop        = press_hit || tick_miss;
    assign miss_inc   = {1'b0, press_bad} + {1'b0, tick_miss};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            pat_step   <= '0;
            btn_q      <= 1'b0;
            press_q    <= 1'b0;
            o_score    <= '0;
            o_miss     <= '0;
            o_overflow <= 1'b0;
            o_playing  <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            state     <= state_next;
            o_playing <= (state_next == PLAY);
            o_done    <= (state_next == DONE);
            btn_q     <= btn_up;
            press_q   <= btn_up && !btn_q;
            if (song_start) begin
                beat_cnt   <= '0;
                pat_step   <= '0;
                o_score    <= '0;
                o_miss     <= '0;
                o_overflow <= 1'b0;
            end else if (playing) begin
                if (beat_wrap) begin
                    beat_cnt <= '0;
                    pat_step <= pat_step + STEP_W'(1);
                end else if (mov_tick && pat_step != STEP_END) begin
                    beat_cnt <= beat_cnt + BEAT_W'(1);
                end
                if (press_hit) begin
                    o_score <= sat_add(o_score, 2'd1);
                end
                o_miss <= sat_add(o_miss, miss_inc);
                if (spawn_req && count == FULL) begin
                    o_overflow <= 1'b1;
                end
            end
        end
    end

    ddr_note_fifo #(
        .N_SLOTS (N_SLOTS),
        .Y_W     (Y_W),
        .STEP    (STEP)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_y     (Y_W'(SPAWN_Y)),
        .pop        (pop),
        .dec        (playing && mov_tick),
        .head_y     (head_y),
        .count      (count),
        .slot_valid (o_valid),
        .slot_y     (o_y)
    );

`ifdef DDR_COMBO_EN
    logic [SCORE_W-1:0] combo;
    logic [SCORE_W-1:0] max_combo;
    logic [SCORE_W-1:0] combo_inc;

    assign combo_inc = sat_add(combo, 2'd1);

    // Best streak survives a new song; only the running streak restarts.
    always_ff @(posedge clk) begin
        if (rst) begin
            combo     <= '0;
            max_combo <= '0;
        end else if (song_start) begin
            combo <= '0;
        end else if (press_hit) begin
            combo <= combo_inc;
            if (combo_inc > max_combo) begin
                max_combo <= combo_inc;
            end
        end else if (press_bad || tick_miss) begin
            combo <= '0;
        end
    end

    assign o_combo     = combo;
    assign o_max_combo = max_combo;
`else
    assign o_combo     = '0;
    assign o_max_combo = '0;
`endif

endmodule

// File: tb/tb_ddr_note_sequencer.sv
// Self-checking bench for ddr_note_sequencer: judging table plus hand-written multi-cycle sequences.
// Spawn pattern 0x1F gives four live arrows 64 px apart and a dropped fifth spawn at tick 80.
module tb_ddr_note_sequencer;
    import ddr_pkg::*;

    localparam int N_SLOTS = 4;
    localparam int Y_W     = 10;
    localparam logic [63:0] TB_PATTERN = 64'h0000_0000_0000_001F;
`ifdef DDR_COMBO_EN
    localparam bit COMBO_ON = 1'b1;
`else
    localparam bit COMBO_ON = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic                   mov_tick;
    logic                   btn_up;
    logic [N_SLOTS-1:0]     o_valid;
    logic [N_SLOTS*Y_W-1:0] o_y;
    logic [9:0]             o_score;
    logic [9:0]             o_miss;
    logic                   o_playing;
    logic                   o_done;
    logic                   o_overflow;
    logic [9:0]             o_combo;
    logic [9:0]             o_max_combo;

    always #5 clk = ~clk;

    ddr_note_sequencer #(
        .N_SLOTS    (N_SLOTS),
        .Y_W        (Y_W),
        .SPAWN_Y    (480),
        .STEP       (4),
        .HIT_LO     (40),
        .HIT_HI     (72),
        .MISS_Y     (8),
        .BEAT_TICKS (16),
        .PAT_LEN    (64),
        .PATTERN    (TB_PATTERN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mov_tick    (mov_tick),
        .btn_up      (btn_up),
        .o_valid     (o_valid),
        .o_y         (o_y),
        .o_score     (o_score),
        .o_miss      (o_miss),
        .o_playing   (o_playing),
        .o_done      (o_done),
        .o_overflow  (o_overflow),
        .o_combo     (o_combo),
        .o_max_combo (o_max_combo)
    );

    typedef struct {
        string      name;
        int         score;
        int         miss;
        logic [3:0] valid;
        logic       ovf;
        logic       playing;
        logic       done;
        int         combo;
        int         max_combo;
        int         slot;
        int         y;
    } exp_t;

    typedef struct {
        int         k;
        int         score;
        int         miss;
        logic [3:0] valid;
        logic       ovf;
        int         slot;
        int         y;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[7];
    int   checks   = 0;
    int   failures = 0;

    task automatic compare(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic void expect_out(input string name, input int score, input int miss,
                                       input logic [3:0] valid, input logic ovf, input logic playing,
                                       input logic done, input int combo, input int max_combo,
                                       input int slot, input int y);
        exp_t e;
        e.name      = name;
        e.score     = score;
        e.miss      = miss;
        e.valid     = valid;
        e.ovf       = ovf;
        e.playing   = playing;
        e.done      = done;
        e.combo     = COMBO_ON ? combo : 0;
        e.max_combo = COMBO_ON ? max_combo : 0;
        e.slot      = slot;
        e.y         = y;
        sb_q.push_back(e);
    endfunction

    task automatic checkOutput();
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL scoreboard: queue empty, nothing expected");
            return;
        end
        e = sb_q.pop_front();
        compare({e.name, ".score"},     int'(o_score),     e.score);
        compare({e.name, ".miss"},      int'(o_miss),      e.miss);
        compare({e.name, ".valid"},     int'(o_valid),     int'(e.valid));
        compare({e.name, ".overflow"},  int'(o_overflow),  int'(e.ovf));
        compare({e.name, ".playing"},   int'(o_playing),   int'(e.playing));
        compare({e.name, ".done"},      int'(o_done),      int'(e.done));
        compare({e.name, ".combo"},     int'(o_combo),     e.combo);
        compare({e.name, ".max_combo"}, int'(o_max_combo), e.max_combo);
        if (e.slot >= 0) begin
            compare({e.name, ".y"}, int'(o_y[e.slot*Y_W +: Y_W]), e.y);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic t, input logic b);
        start    = s;
        mov_tick = t;
        btn_up   = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        mov_tick = 1'b0;
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
        end
    endtask

    // Edge is registered on the first cycle and judged on the second.
    task automatic press(input logic tick_on_judge);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, tick_on_judge, 1'b0);
    endtask

    task automatic start_song();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // k = ticks after the first spawn, so head y = 480 - 4k; arrow 2 trails by 64 px.
        vecs[0] = '{k: 106, score: 1, miss: 0, valid: 4'b1110, ovf: 1'b1, slot: 1, y: 120};
        vecs[1] = '{k: 110, score: 1, miss: 0, valid: 4'b1110, ovf: 1'b1, slot: 1, y: 104};
        vecs[2] = '{k: 102, score: 1, miss: 0, valid: 4'b1110, ovf: 1'b1, slot: 1, y: 136};
        vecs[3] = '{k: 111, score: 0, miss: 1, valid: 4'b1111, ovf: 1'b1, slot: 0, y: 36};
        vecs[4] = '{k: 101, score: 0, miss: 1, valid: 4'b1111, ovf: 1'b1, slot: 0, y: 76};
        vecs[5] = '{k: 0,   score: 0, miss: 1, valid: 4'b0001, ovf: 1'b0, slot: 0, y: 480};
        vecs[6] = '{k: 70,  score: 0, miss: 1, valid: 4'b1111, ovf: 1'b1, slot: 0, y: 200};

        rst = 1'b1; start = 1'b0; mov_tick = 1'b0; btn_up = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        expect_out("reset", 0, 0, 4'b0000, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput();
        rst = 1'b0;
        expect_out("start", 0, 0, 4'b0000, 1'b0, 1'b1, 1'b0, 0, 0, -1, 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput();

        for (int i = 0; i < 7; i++) begin
            start_song();
            do_ticks(16 + vecs[i].k);
            expect_out($sformatf("judge_k%0d", vecs[i].k), vecs[i].score, vecs[i].miss, vecs[i].valid,
                       vecs[i].ovf, 1'b1, 1'b0, vecs[i].score, vecs[i].score, vecs[i].slot, vecs[i].y);
            press(1'b0);
            checkOutput();
        end

        start_song();
        expect_out("empty_press", 0, 1, 4'b0000, 1'b0, 1'b1, 1'b0, 0, 0, -1, 0);
        press(1'b0);
        checkOutput();
        do_ticks(86);
        expect_out("bad_press_200", 0, 2, 4'b1111, 1'b1, 1'b1, 1'b0, 0, 0, 0, 200);
        press(1'b0);
        checkOutput();

        start_song();
        do_ticks(133);
        expect_out("pre_miss_y8", 0, 0, 4'b1111, 1'b1, 1'b1, 1'b0, 0, 0, 0, 8);
        do_ticks(1);
        checkOutput();
        expect_out("tick_miss", 0, 1, 4'b1110, 1'b1, 1'b1, 1'b0, 0, 0, 1, 68);
        do_ticks(1);
        checkOutput();

        start_song();
        do_ticks(78);
        expect_out("full_no_ovf", 0, 0, 4'b1111, 1'b0, 1'b1, 1'b0, 0, 0, 3, 420);
        do_ticks(1);
        checkOutput();
        expect_out("spawn_dropped", 0, 0, 4'b1111, 1'b1, 1'b1, 1'b0, 0, 0, 3, 416);
        do_ticks(1);
        checkOutput();

        start_song();
        do_ticks(119);
        expect_out("hit_with_tick", 1, 0, 4'b1110, 1'b1, 1'b1, 1'b0, 1, 1, 1, 128);
        press(1'b1);
        checkOutput();

        start_song();
        do_ticks(122);
        expect_out("combo_hit1", 1, 0, 4'b1110, 1'b1, 1'b1, 1'b0, 1, 1, 1, 120);
        press(1'b0);
        checkOutput();
        do_ticks(16);
        expect_out("combo_hit2", 2, 0, 4'b1100, 1'b1, 1'b1, 1'b0, 2, 2, 2, 120);
        press(1'b0);
        checkOutput();
        do_ticks(16);
        expect_out("combo_hit3", 3, 0, 4'b1000, 1'b1, 1'b1, 1'b0, 3, 3, 3, 120);
        press(1'b0);
        checkOutput();
        expect_out("combo_break", 3, 1, 4'b1000, 1'b1, 1'b1, 1'b0, 0, 3, 3, 120);
        press(1'b0);
        checkOutput();

        start_song();
        do_ticks(49);
        expect_out("three_live", 0, 0, 4'b0111, 1'b0, 1'b1, 1'b0, 0, 0, 2, 472);
        do_ticks(1);
        checkOutput();
        rst = 1'b1;
        expect_out("mid_song_reset", 0, 0, 4'b0000, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput();
        rst = 1'b0;

        start_song();
        do_ticks(200);
        expect_out("start_ignored", 0, 4, 4'b0000, 1'b1, 1'b1, 1'b0, 0, 0, -1, 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput();
        do_ticks(824);
        expect_out("last_step", 0, 4, 4'b0000, 1'b1, 1'b1, 1'b0, 0, 0, -1, 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        sb_q.pop_back();
        expect_out("song_done", 0, 4, 4'b0000, 1'b1, 1'b0, 1'b1, 0, 0, -1, 0);
        checkOutput();
        expect_out("restart", 0, 0, 4'b0000, 1'b0, 1'b1, 1'b0, 0, 0, -1, 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
